// File: rtl/regfile_wb_stage.sv
// MIPS register file with a one-entry write-back buffer.
// Writes become readable one edge after they are presented and reach the array one edge later.
module regfile_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              wb_pending,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    logic [DATA_W-1:0] regs [NREGS];
    wb_entry_t         wb;
    logic              accept_c;

    // Register $0 is hard-wired, so writes to it are never accepted.
    assign accept_c = we && (wa != '0);

    // Commit the buffered write while capturing the incoming one on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            wb       <= '0;
            wr_count <= '0;
        end else begin
            if (wb.valid) begin
                regs[wb.addr] <= wb.data;
            end
            if (accept_c) begin
                wb.valid <= 1'b1;
                wb.addr  <= wa;
                wb.data  <= wd;
                if (wr_count != CNT_MAX) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end else begin
                wb.valid <= 1'b0;
            end
        end
    end

    assign wb_pending = wb.valid;

    // Read port 1: $0, then buffer bypass, then array.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wb.valid && (wb.addr == ra1)) begin
            rd1 = wb.data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wb.valid && (wb.addr == ra2)) begin
            rd2 = wb.data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Self-checking bench for regfile_wb_stage: directed cases plus random traffic
// against an architectural model (visible register contents, pending flag, write count).
module tb_regfile_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_pending;
    logic [15:0] wr_count;

    regfile_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .wb_pending (wb_pending),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural view: what a reader sees after each edge.
    logic [31:0] m_regs [32];
    logic        m_pend;
    int unsigned m_cnt;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [4:0]  last_wa = 5'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 1'b0;
        m_cnt  = 0;
    endtask

    // One clock: drive at negedge, check pre-edge outputs, then advance model at posedge.
    task automatic cycle(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input bit chk);
        @(negedge clk);
        rst_n = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        #1;
        if (chk) begin
            check("rd1", rd1, m_read(r1));
            check("rd2", rd2, m_read(r2));
            check("wb_pending", {31'd0, wb_pending}, {31'd0, m_pend});
            check("wr_count", {16'd0, wr_count}, m_cnt);
        end
        @(posedge clk);
        if (!r) begin
            m_reset();
        end else begin
            m_pend = w && (a != 5'd0);
            if (m_pend) begin
                m_regs[a] = d;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b1; wa = 5'd5; wd = 32'd7; ra1 = 5'd5; ra2 = 5'd0;
        @(posedge clk);
        m_reset();

        // Reset with a live write request: nothing is captured.
        cycle(1'b0, 1'b1, 5'd5, 32'd7, 5'd5, 5'd5, 1'b1);
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1), 1'b1);

        // Single write: old value same cycle, new value next cycle, pending then clear.
        cycle(1'b1, 1'b1, 5'd5, 32'h7, 5'd5, 5'd5, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1);
        check("wr_count_after_one", {16'd0, wr_count}, 32'd1);
        check("rd1_committed_5", rd1, 32'h7);

        // Writes to $0 are dropped entirely.
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        check("zero_write_pending", {31'd0, wb_pending}, 32'd0);
        check("zero_write_count", {16'd0, wr_count}, 32'd1);

        // Back-to-back writes to the same register.
        cycle(1'b1, 1'b1, 5'd7, 32'd5, 5'd7, 5'd7, 1'b1);
        cycle(1'b1, 1'b1, 5'd7, 32'd9, 5'd7, 5'd7, 1'b1);
        check("b2b_first", rd2, 32'd5);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1);
        check("b2b_second", rd2, 32'd9);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b1);
        check("b2b_settled", rd1, 32'd9);
        check("b2b_count", {16'd0, wr_count}, 32'd3);

        // Reset while a write is buffered discards it.
        cycle(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
        check("reset_discard", rd1, 32'd0);

        // Random traffic with address reuse and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic        r, w;
            logic [4:0]  a, r1, r2;
            logic [31:0] d;
            r  = ($urandom_range(0, 99) >= 2);
            w  = ($urandom_range(0, 99) < 70);
            a  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            d  = $urandom;
            r1 = ($urandom_range(0, 1) == 0) ? last_wa : 5'($urandom);
            r2 = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 7));
            if (w) last_wa = a;
            cycle(r, w, a, d, r1, r2, 1'b1);
        end

        // Saturation: 65537 accepted writes from a cleared counter.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        for (int i = 0; i < 65537; i++)
            cycle(1'b1, 1'b1, 5'(1 + (i % 31)), 32'(i), 5'd1, 5'd2, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 32'hA5A5_0001, 5'd4, 5'd31, 1'b1);
        check("sat_count", {16'd0, wr_count}, 32'h0000_FFFF);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b1);
        check("sat_hold", {16'd0, wr_count}, 32'h0000_FFFF);
        check("sat_bypass", rd1, 32'hA5A5_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
